// File: rtl/wave_pkg.sv
// wave_pkg
//   Shared types and helpers for the multi-channel wave capture stage.
//   - wave_state_e : capture FSM states
//   - TRIG_*       : trigger mode encodings (3 is reserved and behaves as free-run)
//   - to_offset_bin: signed two's-complement -> offset-binary (MSB flip)
package wave_pkg;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_IDLE = 2'd2
    } wave_state_e;

    localparam logic [1:0] TRIG_RISE = 2'd0;
    localparam logic [1:0] TRIG_FALL = 2'd1;
    localparam logic [1:0] TRIG_FREE = 2'd2;

    // Flips bit (width-1) of a right-justified value; callers cast the
    // result back down to their own width.
    function automatic logic [31:0] to_offset_bin(input logic [31:0] msbs, input int width);
        return msbs ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/wave_trigger.sv
// wave_trigger
//   Trigger detector for the capture FSM. Holds the previous sample of the
//   selected channel, a prev-valid flag, the signed edge comparator and the
//   auto-trigger timeout counter.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   armed        : FSM is in ARMED (first such cycle latches trig_* config)
//   rearm        : one-cycle pulse on WAIT_IDLE -> ARMED; forgets prev/config
//   strobe       : accepted sample strobe while ARMED
//   sample       : all channels, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   trig_chan/trig_mode/trig_level : live trigger configuration
//   fire         : one-cycle, combinational; this strobe is the trigger
module wave_trigger
    import wave_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int AUTO_TO  = 4096,
    parameter int CH_W     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         armed,
    input  logic                         rearm,
    input  logic                         strobe,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample,
    input  logic [CH_W-1:0]              trig_chan,
    input  logic [1:0]                   trig_mode,
    input  logic signed [SAMPLE_W-1:0]   trig_level,
    output logic                         fire
);

    localparam int TO_W = (AUTO_TO > 0) ? $clog2(AUTO_TO + 1) : 1;

    logic                       cfg_valid_q, cfg_valid_d;
    logic [CH_W-1:0]            chan_q, chan_d;
    logic [1:0]                 mode_q, mode_d;
    logic signed [SAMPLE_W-1:0] level_q, level_d;
    logic signed [SAMPLE_W-1:0] prev_q, prev_d;
    logic                       prev_valid_q, prev_valid_d;
    logic [TO_W-1:0]            cnt_q, cnt_d;

    logic [CH_W-1:0]            chan;
    logic [1:0]                 mode;
    logic signed [SAMPLE_W-1:0] level;
    logic signed [SAMPLE_W-1:0] cur;
    logic                       edge_hit;
    logic                       timeout;

    always_comb begin
        // Until the first ARMED cycle has latched the config, the live inputs
        // are used, so a strobe landing in that very cycle sees the same values.
        chan  = cfg_valid_q ? chan_q  : trig_chan;
        mode  = cfg_valid_q ? mode_q  : trig_mode;
        level = cfg_valid_q ? level_q : trig_level;
        cur   = sample[chan*SAMPLE_W +: SAMPLE_W];

        case (mode)
            TRIG_RISE: edge_hit = prev_valid_q && (prev_q < level) && (level <= cur);
            TRIG_FALL: edge_hit = prev_valid_q && (prev_q >= level) && (level > cur);
            default:   edge_hit = 1'b1;
        endcase

        // The strobe that brings the count to AUTO_TO is itself the trigger.
        timeout = (AUTO_TO != 0) && ((int'(cnt_q) + 1) == AUTO_TO);
        fire    = strobe && (edge_hit || timeout);

        cfg_valid_d  = cfg_valid_q;
        chan_d       = chan_q;
        mode_d       = mode_q;
        level_d      = level_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        cnt_d        = cnt_q;

        if (rearm) begin
            cfg_valid_d  = 1'b0;
            prev_valid_d = 1'b0;
            cnt_d        = '0;
        end else begin
            if (armed && !cfg_valid_q) begin
                cfg_valid_d = 1'b1;
                chan_d      = trig_chan;
                mode_d      = trig_mode;
                level_d     = trig_level;
            end
            if (strobe) begin
                prev_d       = cur;
                prev_valid_d = 1'b1;
                cnt_d        = cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_valid_q  <= 1'b0;
            chan_q       <= '0;
            mode_q       <= '0;
            level_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            cfg_valid_q  <= cfg_valid_d;
            chan_q       <= chan_d;
            mode_q       <= mode_d;
            level_q      <= level_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: rtl/wave_capture_mc.sv
// wave_capture_mc
//   Triggered multi-channel capture into a ping-pong sample RAM. One frame of
//   2^DEPTH_LOG2 samples per channel goes into bank ~read_index; banks swap
//   only once the frame is complete and the display reports idle.
// Handshake: new_sample is a one-cycle strobe with no back-pressure. A strobe
//   is accepted only when the write serialiser is free; a strobe that arrives
//   while channels are still being written is dropped and sets sticky overrun
//   (strobes in WAIT_IDLE are ignored silently).
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   new_sample, sample : input strobe and all channel samples
//   trig_chan/mode/level: trigger configuration, latched on ARMED entry
//   wave_display_idle  : display is not scanning
//   write_enable/address/sample : RAM write port, address {bank, chan, index}
//   read_index         : bank currently shown by the display
//   busy, overrun      : status
//   state_dbg          : current FSM state
module wave_capture_mc
    import wave_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 16,
    parameter int DISP_W     = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int AUTO_TO    = 4096,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW        = 1 + CH_W + DEPTH_LOG2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_sample,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample,
    input  logic [CH_W-1:0]              trig_chan,
    input  logic [1:0]                   trig_mode,
    input  logic signed [SAMPLE_W-1:0]   trig_level,
    input  logic                         wave_display_idle,
    output logic                         write_enable,
    output logic [AW-1:0]                write_address,
    output logic [DISP_W-1:0]            write_sample,
    output logic                         read_index,
    output logic                         busy,
    output logic                         overrun,
    output logic [1:0]                   state_dbg
);

    function automatic logic [DISP_W-1:0] conv(input logic [SAMPLE_W-1:0] s);
        return DISP_W'(to_offset_bin(32'(s[SAMPLE_W-1 -: DISP_W]), DISP_W));
    endfunction

    wave_state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]        index_q, index_d;
    logic [CH_W-1:0]              ser_ch_q, ser_ch_d;
    logic [CHANNELS*SAMPLE_W-1:0] lat_q, lat_d;
    logic                         we_q, we_d;
    logic [AW-1:0]                addr_q, addr_d;
    logic [DISP_W-1:0]            wdata_q, wdata_d;
    logic                         read_index_q, read_index_d;
    logic                         busy_q, busy_d;
    logic                         overrun_q, overrun_d;

    logic                  accept;
    logic                  trig_strobe;
    logic                  fire;
    logic                  rearm;
    logic                  start_write;
    logic                  last_ch;
    logic [CH_W-1:0]       nxt_ch;
    logic [DEPTH_LOG2-1:0] wr_index;

    wave_trigger #(
        .CHANNELS (CHANNELS),
        .SAMPLE_W (SAMPLE_W),
        .AUTO_TO  (AUTO_TO),
        .CH_W     (CH_W)
    ) u_trigger (
        .clk        (clk),
        .reset      (reset),
        .armed      (state_q == ARMED),
        .rearm      (rearm),
        .strobe     (trig_strobe),
        .sample     (sample),
        .trig_chan  (trig_chan),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .fire       (fire)
    );

    always_comb begin
        // write_enable doubles as "serialiser busy": it is high for exactly
        // the CHANNELS cycles following an accepted strobe.
        accept      = new_sample && !we_q && (state_q != WAIT_IDLE);
        trig_strobe = accept && (state_q == ARMED);
        last_ch     = (int'(ser_ch_q) == CHANNELS - 1);
        nxt_ch      = ser_ch_q + CH_W'(1);

        state_d      = state_q;
        index_d      = index_q;
        read_index_d = read_index_q;
        rearm        = 1'b0;
        start_write  = 1'b0;
        wr_index     = index_q;

        case (state_q)
            ARMED: begin
                if (fire) begin
                    start_write = 1'b1;
                    wr_index    = '0;
                    index_d     = '0;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    start_write = 1'b1;
                    wr_index    = index_q + DEPTH_LOG2'(1);
                    index_d     = wr_index;
                end
                // Last channel of the last index is on the write port now.
                if (we_q && last_ch && (&index_q)) begin
                    state_d = WAIT_IDLE;
                    index_d = '0;
                end
            end
            WAIT_IDLE: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                    rearm        = 1'b1;
                end
            end
            default: state_d = ARMED;
        endcase

        we_d     = 1'b0;
        ser_ch_d = ser_ch_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (start_write) begin
            // Channel 0 goes straight from the input; the rest from the latch.
            we_d     = 1'b1;
            ser_ch_d = '0;
            lat_d    = sample;
            addr_d   = {~read_index_q, CH_W'(0), wr_index};
            wdata_d  = conv(sample[SAMPLE_W-1:0]);
        end else if (we_q && !last_ch) begin
            we_d     = 1'b1;
            ser_ch_d = nxt_ch;
            addr_d   = {~read_index_q, nxt_ch, index_q};
            wdata_d  = conv(lat_q[nxt_ch*SAMPLE_W +: SAMPLE_W]);
        end

        busy_d    = (state_d == CAPTURE) || we_d;
        overrun_d = overrun_q || (new_sample && we_q && (state_q != WAIT_IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARMED;
            index_q      <= '0;
            ser_ch_q     <= '0;
            lat_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            read_index_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            ser_ch_q     <= ser_ch_d;
            lat_q        <= lat_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            read_index_q <= read_index_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign write_enable  = we_q;
    assign write_address = addr_q;
    assign write_sample  = wdata_q;
    assign read_index    = read_index_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign state_dbg     = state_q;

endmodule
